mem_arbiter: RTL and testbench

Shares the single-port, byte-enabled simulation/unified memory between the core's instruction-fetch port and its load/store port. Arbitrates one access per cycle and drives the memory's address, write data and byte enables. Returns each read response to the port that issued it one cycle later. On the data port it performs RISC-V load/store lane alignment, sign/zero extension and misalignment detection, so the core presents plain byte/half/word accesses.

---
 rtl/mem_arbiter_pkg.sv | 43 ++++
 rtl/mem_arbiter_lane_align.sv | 72 +++++++
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the fetch/load-store memory arbiter: address/data words,
// access sizes, port identifiers and the one-stage response record.
package mem_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'b00,
    MEM_HALF = 2'b01,
    MEM_WORD = 2'b10,
    MEM_ILL  = 2'b11
  } mem_size_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_sel_t;

  // Everything the response cycle needs to route and shape the memory word.
  typedef struct packed {
    logic      valid;
    port_sel_t owner;
    mem_size_t size;
    logic [1:0] off;
    logic      uns;
    logic      err;
    logic      we;
  } rsp_t;

  function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] off);
    logic bad;
    case (size)
      MEM_BYTE: bad = 1'b0;
      MEM_HALF: bad = off[0];
      MEM_WORD: bad = (off != 2'b00);
      default:  bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Combinational RISC-V lane handling: store byte-enable/data replication,
// misalignment detection, and load byte/half extraction with extension.
module mem_lane_align
  import mem_arbiter_pkg::*;
(
  input  mem_size_t  req_size_i,
  input  logic [1:0] req_off_i,
  input  data_t      req_wdata_i,
  output byte_en_t   st_be_o,
  output data_t      st_data_o,
  output logic       misaligned_o,
  input  mem_size_t  rsp_size_i,
  input  logic [1:0] rsp_off_i,
  input  logic       rsp_uns_i,
  input  data_t      rd_data_i,
  output data_t      ld_data_o
);

  logic  bad;
  data_t rd_shifted;
  logic  ext_bit;

  assign bad          = is_misaligned(req_size_i, req_off_i);
  assign misaligned_o = bad;

  always_comb begin
    st_be_o   = '0;
    st_data_o = req_wdata_i;
    case (req_size_i)
      MEM_BYTE: begin
        st_be_o   = byte_en_t'(4'b0001 << req_off_i);
        st_data_o = {4{req_wdata_i[7:0]}};
      end
      MEM_HALF: begin
        st_be_o   = byte_en_t'(4'b0011 << req_off_i);
        st_data_o = {2{req_wdata_i[15:0]}};
      end
      MEM_WORD: begin
        st_be_o   = 4'b1111;
        st_data_o = req_wdata_i;
      end
      default: begin
        st_be_o   = '0;
        st_data_o = req_wdata_i;
      end
    endcase
    // A misaligned store must never touch memory.
    if (bad) begin
      st_be_o = '0;
    end
  end

  assign rd_shifted = rd_data_i >> {rsp_off_i, 3'b000};

  always_comb begin
    ld_data_o = '0;
    ext_bit   = 1'b0;
    case (rsp_size_i)
      MEM_BYTE: begin
        ext_bit   = ~rsp_uns_i & rd_shifted[7];
        ld_data_o = {{24{ext_bit}}, rd_shifted[7:0]};
      end
      MEM_HALF: begin
        ext_bit   = ~rsp_uns_i & rd_shifted[15];
        ld_data_o = {{16{ext_bit}}, rd_shifted[15:0]};
      end
      MEM_WORD: ld_data_o = rd_data_i;
      default:  ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store.
// Grants one access per cycle and returns the response one cycle later.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      i_req_valid,
  output logic      i_req_ready,
  input  addr_t     i_addr,
  output logic      i_rvalid,
  output data_t     i_rdata,
  input  logic      d_req_valid,
  output logic      d_req_ready,
  input  addr_t     d_addr,
  input  logic      d_we,
  input  mem_size_t d_size,
  input  logic      d_unsigned,
  input  data_t     d_wdata,
  output logic      d_rvalid,
  output data_t     d_rdata,
  output logic      d_err,
  output addr_t     mem_address,
  output data_t     mem_write_data,
  output byte_en_t  mem_write_enable,
  input  data_t     mem_read_data
);

  // Handshake: a request is accepted in the cycle where valid && ready; the
  // requester holds it until then. Responses carry no backpressure and are
  // presented for exactly one cycle, one cycle after acceptance.

  logic      grant_i;
  logic      grant_d;
  port_sel_t last_grant_q, last_grant_d;
  rsp_t      rsp_q, rsp_d;

  byte_en_t  st_be;
  data_t     st_data;
  logic      d_misaligned;
  data_t     ld_data;
  logic      unused_fetch_off;

  assign unused_fetch_off = ^i_addr[1:0];

  mem_lane_align u_lane_align (
    .req_size_i   (d_size),
    .req_off_i    (d_addr[1:0]),
    .req_wdata_i  (d_wdata),
    .st_be_o      (st_be),
    .st_data_o    (st_data),
    .misaligned_o (d_misaligned),
    .rsp_size_i   (rsp_q.size),
    .rsp_off_i    (rsp_q.off),
    .rsp_uns_i    (rsp_q.uns),
    .rd_data_i    (mem_read_data),
    .ld_data_o    (ld_data)
  );

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (!reset) begin
      if (i_req_valid && d_req_valid) begin
        // Fair mode alternates; the reset value of last_grant hands the
        // first contention to the data port.
        if (FAIR && (last_grant_q == PORT_D)) begin
          grant_i = 1'b1;
        end else begin
          grant_d = 1'b1;
        end
      end else begin
        grant_i = i_req_valid;
        grant_d = d_req_valid;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    rsp_d        = '0;
    if (grant_i) begin
      last_grant_d = PORT_I;
      rsp_d.valid  = 1'b1;
      rsp_d.owner  = PORT_I;
      rsp_d.size   = MEM_WORD;
    end
    if (grant_d) begin
      last_grant_d = PORT_D;
      rsp_d.valid  = 1'b1;
      rsp_d.owner  = PORT_D;
      rsp_d.size   = d_size;
      rsp_d.off    = d_addr[1:0];
      rsp_d.uns    = d_unsigned;
      rsp_d.err    = d_misaligned;
      rsp_d.we     = d_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_q        <= '0;
      last_grant_q <= PORT_I;
    end else begin
      rsp_q        <= rsp_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign i_req_ready      = grant_i;
  assign d_req_ready      = grant_d;
  assign mem_address      = grant_d ? {d_addr[31:2], 2'b00} : {i_addr[31:2], 2'b00};
  assign mem_write_data   = st_data;
  assign mem_write_enable = (grant_d && d_we) ? st_be : '0;

  // Gating with reset drops a response whose acceptance is followed by reset.
  assign i_rvalid = rsp_q.valid && (rsp_q.owner == PORT_I) && !reset;
  assign i_rdata  = mem_read_data;
  assign d_rvalid = rsp_q.valid && (rsp_q.owner == PORT_D) && !reset;
  assign d_err    = d_rvalid && rsp_q.err;
  assign d_rdata  = (d_rvalid && !rsp_q.err && !rsp_q.we) ? ld_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run checked
// against a byte-array memory model with arithmetic lane/extension rules.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic      i_req_valid, i_req_ready, i_rvalid;
  addr_t     i_addr;
  data_t     i_rdata;
  logic      d_req_valid, d_req_ready, d_we, d_unsigned, d_rvalid, d_err;
  addr_t     d_addr;
  mem_size_t d_size;
  data_t     d_wdata, d_rdata;
  addr_t     mem_address;
  data_t     mem_write_data, mem_read_data;
  byte_en_t  mem_write_enable;

  logic      f0_i_ready, f0_i_rvalid, f0_d_ready, f0_d_rvalid, f0_d_err;
  data_t     f0_i_rdata, f0_d_rdata, f0_wdata;
  addr_t     f0_addr;
  byte_en_t  f0_we;
  data_t     f0_rd_data;
  assign f0_rd_data = 32'h0;

  mem_arbiter #(.FAIR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_data(mem_read_data)
  );

  mem_arbiter #(.FAIR(1'b0)) dut_f0 (
    .clk(clk), .reset(reset),
    .i_req_valid(i_req_valid), .i_req_ready(f0_i_ready), .i_addr(i_addr),
    .i_rvalid(f0_i_rvalid), .i_rdata(f0_i_rdata),
    .d_req_valid(d_req_valid), .d_req_ready(f0_d_ready), .d_addr(d_addr),
    .d_we(d_we), .d_size(d_size), .d_unsigned(d_unsigned), .d_wdata(d_wdata),
    .d_rvalid(f0_d_rvalid), .d_rdata(f0_d_rdata), .d_err(f0_d_err),
    .mem_address(f0_addr), .mem_write_data(f0_wdata),
    .mem_write_enable(f0_we), .mem_read_data(f0_rd_data)
  );

  // Registered single-port byte-enabled memory, 1 KiB.
  data_t tb_mem [0:255];
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (mem_write_enable[k]) tb_mem[mem_address[9:2]][8*k +: 8] <= mem_write_data[8*k +: 8];
    end
    mem_read_data <= tb_mem[mem_address[9:2]];
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic     s_i_ready, s_d_ready, s_f0_i_ready, s_f0_d_ready;
  addr_t    s_addr;
  byte_en_t s_be;
  data_t    s_wdata;
  logic     r_i_rvalid, r_d_rvalid, r_d_err, r_f0_i_rvalid, r_f0_d_rvalid;
  data_t    r_i_rdata, r_d_rdata;

  logic [7:0] ref_mem [0:255];

  task automatic drive_cycle(input logic iv, input addr_t ia, input logic dv, input addr_t da,
                             input logic dwe, input logic [1:0] dsz, input logic dun, input data_t dwd);
    i_req_valid = iv; i_addr = ia;
    d_req_valid = dv; d_addr = da; d_we = dwe; d_size = mem_size_t'(dsz);
    d_unsigned = dun; d_wdata = dwd;
    #1;
    s_i_ready = i_req_ready; s_d_ready = d_req_ready;
    s_f0_i_ready = f0_i_ready; s_f0_d_ready = f0_d_ready;
    s_addr = mem_address; s_be = mem_write_enable; s_wdata = mem_write_data;
    @(posedge clk); #1;
    r_i_rvalid = i_rvalid; r_i_rdata = i_rdata;
    r_d_rvalid = d_rvalid; r_d_rdata = d_rdata; r_d_err = d_err;
    r_f0_i_rvalid = f0_i_rvalid; r_f0_d_rvalid = f0_d_rvalid;
    @(negedge clk);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      i_req_valid = 1'b1; i_addr = 32'h20; d_req_valid = 1'b1; d_addr = 32'h0;
      d_we = 1'b0; d_size = MEM_WORD; d_unsigned = 1'b0; d_wdata = 32'h0;
      #1;
      n_checks++;
      if ({i_req_ready, d_req_ready, f0_i_ready, f0_d_ready} !== 4'b0000) begin
        n_fail++; $display("FAIL reset_ready cycle %0d: got %b%b%b%b want 0000", c,
                           i_req_ready, d_req_ready, f0_i_ready, f0_d_ready);
      end
      n_checks++;
      if (mem_write_enable !== 4'b0000) begin
        n_fail++; $display("FAIL reset_we cycle %0d: got %b want 0000", c, mem_write_enable);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({i_rvalid, d_rvalid, d_err} !== 3'b000) begin
        n_fail++; $display("FAIL reset_rvalid cycle %0d: got %b%b%b want 000", c, i_rvalid, d_rvalid, d_err);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    // Requests held through reset are arbitrated right away; data wins first.
    drive_cycle(1'b1, 32'h20, 1'b1, 32'h0, 1'b0, 2'd2, 1'b0, 32'h0);
    n_checks++;
    if ({s_i_ready, s_d_ready} !== 2'b01) begin
      n_fail++; $display("FAIL post_reset_grant: got i=%b d=%b want i=0 d=1", s_i_ready, s_d_ready);
    end
  endtask

  task automatic test_fetch();
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF);
    drive_cycle(1'b1, 32'h12, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0, 32'h0);
    n_checks++;
    if (s_i_ready !== 1'b1 || s_addr !== 32'h10) begin
      n_fail++; $display("FAIL fetch_req: got ready=%b addr=%h want ready=1 addr=00000010", s_i_ready, s_addr);
    end
    n_checks++;
    if (r_i_rvalid !== 1'b1 || r_i_rdata !== 32'hDEADBEEF || r_d_rvalid !== 1'b0) begin
      n_fail++; $display("FAIL fetch_rsp: got iv=%b data=%h dv=%b want 1 deadbeef 0", r_i_rvalid, r_i_rdata, r_d_rvalid);
    end
  endtask

  task automatic test_stores();
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h13, 1'b1, 2'd0, 1'b0, 32'h000000AB);
    n_checks++;
    if (s_be !== 4'b1000 || s_wdata !== 32'hABABABAB) begin
      n_fail++; $display("FAIL sb_lanes: got be=%b data=%h want 1000 abababab", s_be, s_wdata);
    end
    n_checks++;
    if (r_d_rvalid !== 1'b1 || r_d_err !== 1'b0 || r_d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL sb_rsp: got v=%b err=%b data=%h want 1 0 0", r_d_rvalid, r_d_err, r_d_rdata);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h12, 1'b1, 2'd1, 1'b0, 32'h00001234);
    n_checks++;
    if (s_be !== 4'b1100 || s_wdata !== 32'h12341234) begin
      n_fail++; $display("FAIL sh_lanes: got be=%b data=%h want 1100 12341234", s_be, s_wdata);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h10, 1'b1, 2'd2, 1'b0, 32'h1234ABCD);
    n_checks++;
    if (s_be !== 4'b1111 || s_wdata !== 32'h1234ABCD || s_addr !== 32'h10) begin
      n_fail++; $display("FAIL sw_lanes: got be=%b data=%h addr=%h want 1111 1234abcd 00000010", s_be, s_wdata, s_addr);
    end
  endtask

  task automatic test_loads();
    addr_t      la [5] = '{32'h13, 32'h11, 32'h10, 32'h10, 32'h10};
    logic [1:0] ls [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    logic       lu [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    data_t      le [5] = '{32'h00000012, 32'hFFFFFFAB, 32'hFFFFABCD, 32'h0000ABCD, 32'h1234ABCD};
    for (int n = 0; n < 5; n++) begin
      drive_cycle(1'b0, 32'h0, 1'b1, la[n], 1'b0, ls[n], lu[n], 32'h0);
      n_checks++;
      if (r_d_rvalid !== 1'b1 || r_d_err !== 1'b0 || r_d_rdata !== le[n]) begin
        n_fail++; $display("FAIL load_%0d: got v=%b err=%b data=%h want 1 0 %h", n, r_d_rvalid, r_d_err, r_d_rdata, le[n]);
      end
    end
  endtask

  task automatic test_contention();
    logic exp_d [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int n = 0; n < 4; n++) begin
      drive_cycle(1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 2'd2, 1'b0, 32'h0);
      n_checks++;
      if (s_d_ready !== exp_d[n] || s_i_ready !== !exp_d[n]) begin
        n_fail++; $display("FAIL fair_grant_%0d: got i=%b d=%b want d=%b", n, s_i_ready, s_d_ready, exp_d[n]);
      end
      n_checks++;
      if (r_d_rvalid !== exp_d[n] || r_i_rvalid !== !exp_d[n]) begin
        n_fail++; $display("FAIL fair_rsp_%0d: got iv=%b dv=%b want dv=%b", n, r_i_rvalid, r_d_rvalid, exp_d[n]);
      end
      n_checks++;
      if (s_f0_d_ready !== 1'b1 || s_f0_i_ready !== 1'b0 || r_f0_i_rvalid !== 1'b0 || r_f0_d_rvalid !== 1'b1) begin
        n_fail++; $display("FAIL prio_grant_%0d: got ir=%b dr=%b iv=%b dv=%b want 0 1 0 1", n,
                           s_f0_i_ready, s_f0_d_ready, r_f0_i_rvalid, r_f0_d_rvalid);
      end
    end
  endtask

  task automatic test_errors();
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h102, 1'b0, 2'd2, 1'b0, 32'h0);
    n_checks++;
    if (s_d_ready !== 1'b1 || s_be !== 4'b0000) begin
      n_fail++; $display("FAIL lw_mis_req: got ready=%b be=%b want 1 0000", s_d_ready, s_be);
    end
    n_checks++;
    if (r_d_rvalid !== 1'b1 || r_d_err !== 1'b1 || r_d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL lw_mis_rsp: got v=%b err=%b data=%h want 1 1 0", r_d_rvalid, r_d_err, r_d_rdata);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 2'd2, 1'b0, 32'h55667788);
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h101, 1'b1, 2'd1, 1'b0, 32'h0000AAAA);
    n_checks++;
    if (s_be !== 4'b0000 || r_d_err !== 1'b1 || r_d_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL sh_mis: got be=%b err=%b v=%b want 0000 1 1", s_be, r_d_err, r_d_rvalid);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 2'd3, 1'b0, 32'h0);
    n_checks++;
    if (r_d_err !== 1'b1 || r_d_rdata !== 32'h0) begin
      n_fail++; $display("FAIL size_ill: got err=%b data=%h want 1 0", r_d_err, r_d_rdata);
    end
    drive_cycle(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 2'd2, 1'b0, 32'h0);
    n_checks++;
    if (r_d_rdata !== 32'h55667788 || r_d_err !== 1'b0) begin
      n_fail++; $display("FAIL sh_mis_mem: got data=%h err=%b want 55667788 0", r_d_rdata, r_d_err);
    end
  endtask

  task automatic test_reset_mid();
    i_req_valid = 1'b0; d_req_valid = 1'b1; d_addr = 32'h10; d_we = 1'b0;
    d_size = MEM_WORD; d_unsigned = 1'b0;
    #1;
    n_checks++;
    if (d_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_accept: got %b want 1", d_req_ready);
    end
    @(posedge clk); #1;
    d_req_valid = 1'b0; reset = 1'b1;
    #1;
    n_checks++;
    if ({d_rvalid, i_rvalid, d_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_rsp: got dv=%b iv=%b err=%b want 000", d_rvalid, i_rvalid, d_err);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic       iv, dv, dwe, dun, last_d, exp_i, exp_d, bad;
    logic [1:0] dsz;
    addr_t      ia, da, exp_addr;
    data_t      dwd, v;
    int         nbytes, off, base;
    byte_en_t   exp_be;
    do_reset();
    last_d = 1'b0;
    for (int w = 0; w < 64; w++) begin
      v = $urandom;
      drive_cycle(1'b0, 32'h0, 1'b1, addr_t'(w * 4), 1'b1, 2'd2, 1'b0, v);
      for (int k = 0; k < 4; k++) ref_mem[w*4 + k] = v[8*k +: 8];
    end
    last_d = 1'b1;
    for (int n = 0; n < 200; n++) begin
      iv = 1'($urandom_range(0, 1)); dv = 1'($urandom_range(0, 1));
      ia = addr_t'($urandom_range(0, 255)); da = addr_t'($urandom_range(0, 255));
      dwe = 1'($urandom_range(0, 1)); dun = 1'($urandom_range(0, 1));
      dsz = 2'($urandom_range(0, 3)); dwd = $urandom;
      if (iv && dv) begin
        exp_d = !last_d; exp_i = last_d;
      end else begin
        exp_d = dv; exp_i = iv;
      end
      if (exp_i || exp_d) last_d = exp_d;
      nbytes   = (dsz == 2'd0) ? 1 : (dsz == 2'd1) ? 2 : 4;
      off      = int'(da) % 4;
      bad      = (dsz == 2'd3) || ((int'(da) % nbytes) != 0);
      exp_be   = (exp_d && dwe && !bad) ? byte_en_t'(((1 << nbytes) - 1) << off) : 4'b0000;
      exp_addr = exp_d ? (da & ~32'h3) : (ia & ~32'h3);
      drive_cycle(iv, ia, dv, da, dwe, dsz, dun, dwd);
      n_checks++;
      if (s_i_ready !== exp_i || s_d_ready !== exp_d) begin
        n_fail++; $display("FAIL rnd_grant_%0d: got i=%b d=%b want i=%b d=%b", n, s_i_ready, s_d_ready, exp_i, exp_d);
      end
      n_checks++;
      if (s_addr !== exp_addr || s_be !== exp_be) begin
        n_fail++; $display("FAIL rnd_mem_%0d: got addr=%h be=%b want %h %b", n, s_addr, s_be, exp_addr, exp_be);
      end
      n_checks++;
      if (r_i_rvalid !== exp_i || r_d_rvalid !== exp_d) begin
        n_fail++; $display("FAIL rnd_rvalid_%0d: got iv=%b dv=%b want %b %b", n, r_i_rvalid, r_d_rvalid, exp_i, exp_d);
      end
      if (exp_i) begin
        base = int'(ia) & ~3;
        v = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        n_checks++;
        if (r_i_rdata !== v) begin
          n_fail++; $display("FAIL rnd_fetch_%0d: got %h want %h", n, r_i_rdata, v);
        end
      end
      if (exp_d) begin
        v = 32'h0;
        if (!bad && !dwe) begin
          for (int k = 0; k < nbytes; k++) v = v | (data_t'(ref_mem[int'(da) + k]) << (8 * k));
          if (!dun && nbytes < 4 && ((v >> (8 * nbytes - 1)) & 32'h1) == 32'h1)
            v = v | ~((32'h1 << (8 * nbytes)) - 32'h1);
        end
        n_checks++;
        if (r_d_err !== bad || r_d_rdata !== v) begin
          n_fail++; $display("FAIL rnd_data_%0d: got err=%b data=%h want %b %h", n, r_d_err, r_d_rdata, bad, v);
        end
        if (!bad && dwe) begin
          for (int k = 0; k < nbytes; k++) ref_mem[int'(da) + k] = dwd[8*k +: 8];
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    i_req_valid = 1'b0; i_addr = '0; d_req_valid = 1'b0; d_addr = '0;
    d_we = 1'b0; d_size = MEM_BYTE; d_unsigned = 1'b0; d_wdata = '0;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_stores();
    test_loads();
    test_contention();
    test_errors();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
